// File: rtl/raster_tiler.sv
// raster_tiler
//   Upstream feeder for the 2x2 downsampling sampler. Buffers eight raster
//   rows per bank in a two-bank strip memory and re-emits each full strip as
//   consecutive 8x8 tiles (64 pixels, tile-local row-major). Each tile is
//   followed by a one-cycle DONE and TILE_GAP idle cycles.
//
// Parameters
//   IMG_WIDTH  : pixels per row (multiple of 8, >= 8)
//   IMG_HEIGHT : rows per frame (multiple of 8)
//   TILE_GAP   : idle cycles after each Output_Tile_Done (>= 18)
//
// Ports
//   Clock             in   sole clock, rising edge
//   Input_Reset       in   asynchronous active-low reset
//   Input_Pixel[15:0] in   raster pixel
//   Input_Valid       in   pixel present
//   Input_Frame_Start in   pixel is row 0 / col 0 of a new frame
//   Input_Ready       out  a pixel is accepted this cycle if Input_Valid
//   Output_Pixel[15:0]out  tile pixel (registered)
//   Output_Valid      out  Output_Pixel valid (registered)
//   Output_Tile_Done  out  one-cycle pulse after the 64th pixel of a tile
//   Output_Frame_Done out  pulse with the last tile's Output_Tile_Done
//   Watch[15:0]       out  debug: stalled-input cycle count
//
// Build option
//   TILER_OVERRUN_CNT_EN : when defined, Watch counts cycles with
//   Input_Valid=1 and Input_Ready=0 (saturating, cleared by an accepted
//   Input_Frame_Start). When undefined, Watch is tied to 0.
//
// Handshake: a pixel transfers on a rising edge where Input_Valid and
// Input_Ready are both 1. Input_Ready depends only on registered state, so it
// never combinationally follows Input_Valid; the source may hold Input_Valid
// high while Input_Ready is 0 and must keep the pixel stable until transfer.

module raster_tiler #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int TILE_GAP   = 20
) (
  input  logic        Clock,
  input  logic        Input_Reset,
  input  logic [15:0] Input_Pixel,
  input  logic        Input_Valid,
  input  logic        Input_Frame_Start,
  output logic        Input_Ready,
  output logic [15:0] Output_Pixel,
  output logic        Output_Valid,
  output logic        Output_Tile_Done,
  output logic        Output_Frame_Done,
  output logic [15:0] Watch
);

  localparam int TILES   = IMG_WIDTH / 8;
  localparam int STRIPS  = IMG_HEIGHT / 8;
  localparam int COL_W   = $clog2(IMG_WIDTH);
  localparam int TILE_W  = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int STRIP_W = (STRIPS > 1) ? $clog2(STRIPS) : 1;
  localparam int GAP_W   = $clog2(TILE_GAP);
  localparam int DEPTH   = 16 * IMG_WIDTH;
  localparam int ADDR_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE, S_GAP} state_e;

  // ---------------- write side ----------------
  logic               ready_en_q;
  logic [1:0]         full_q, full_d;
  logic               wr_bank_q;
  logic [2:0]         wr_row_q;
  logic [COL_W-1:0]   wr_col_q;
  logic               accept;
  logic               strip_fill;
  logic [ADDR_W-1:0]  wr_addr;

  // ---------------- read side ----------------
  state_e             state_q, state_d;
  logic [TILE_W-1:0]  tile_q, tile_d;
  logic [5:0]         idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               rd_bank_q;
  logic [STRIP_W-1:0] strip_q;
  logic               release_s, emit_s, done_s, fdone_s;
  logic [ADDR_W-1:0]  rd_addr;

  // Memory read stage between FSM and output registers.
  logic [15:0]        rd_data_q;
  logic               v1_q, done1_q, fd1_q;

  logic [15:0]        mem_q [DEPTH];

  // ready_en_q holds Input_Ready low until the first edge after reset.
  assign Input_Ready = ready_en_q & ~full_q[wr_bank_q];
  assign accept      = Input_Valid & Input_Ready;
  assign strip_fill  = accept & ~Input_Frame_Start & (wr_row_q == 3'd7) &
                       (wr_col_q == COL_W'(IMG_WIDTH - 1));

  // A frame start always lands at row 0 / col 0 of the current write bank.
  always_comb begin
    wr_addr = ADDR_W'(wr_bank_q) * ADDR_W'(8 * IMG_WIDTH);
    if (!Input_Frame_Start) begin
      wr_addr = wr_addr + ADDR_W'(wr_row_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(wr_col_q);
    end
  end

  assign rd_addr = ADDR_W'(rd_bank_q) * ADDR_W'(8 * IMG_WIDTH) +
                   ADDR_W'(idx_q[5:3]) * ADDR_W'(IMG_WIDTH) +
                   ADDR_W'(tile_q) * ADDR_W'(8) + ADDR_W'(idx_q[2:0]);

  // Release and fill always target different banks (one is full, the other
  // is not), so both updates can apply in the same cycle.
  always_comb begin
    full_d = full_q;
    if (release_s)  full_d[rd_bank_q] = 1'b0;
    if (strip_fill) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (accept) mem_q[wr_addr] <= Input_Pixel;
    rd_data_q <= mem_q[rd_addr];
  end

  always_ff @(posedge Clock or negedge Input_Reset) begin
    if (!Input_Reset) begin
      ready_en_q <= 1'b0;
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      wr_row_q   <= 3'd0;
      wr_col_q   <= '0;
      rd_bank_q  <= 1'b0;
      strip_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      full_q     <= full_d;
      if (accept) begin
        if (Input_Frame_Start) begin
          wr_row_q <= 3'd0;
          wr_col_q <= COL_W'(1);
        end else if (wr_col_q == COL_W'(IMG_WIDTH - 1)) begin
          wr_col_q <= '0;
          if (wr_row_q == 3'd7) begin
            wr_row_q  <= 3'd0;
            wr_bank_q <= ~wr_bank_q;
          end else begin
            wr_row_q <= wr_row_q + 3'd1;
          end
        end else begin
          wr_col_q <= wr_col_q + COL_W'(1);
        end
      end
      if (release_s) rd_bank_q <= ~rd_bank_q;
      if (accept && Input_Frame_Start) begin
        strip_q <= '0;
      end else if (release_s) begin
        strip_q <= (strip_q == STRIP_W'(STRIPS - 1)) ? '0 : strip_q + STRIP_W'(1);
      end
    end
  end

  // ---------------- read FSM ----------------
  always_comb begin
    state_d   = state_q;
    tile_d    = tile_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    release_s = 1'b0;
    emit_s    = 1'b0;
    done_s    = 1'b0;
    fdone_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = S_EMIT;
          tile_d  = '0;
          idx_d   = 6'd0;
        end
      end
      S_EMIT: begin
        emit_s = 1'b1;
        idx_d  = idx_q + 6'd1;
        if (idx_q == 6'd63) state_d = S_DONE;
      end
      S_DONE: begin
        done_s  = 1'b1;
        fdone_s = (tile_q == TILE_W'(TILES - 1)) && (strip_q == STRIP_W'(STRIPS - 1));
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(TILE_GAP - 1)) begin
          if (tile_q != TILE_W'(TILES - 1)) begin
            tile_d  = tile_q + TILE_W'(1);
            idx_d   = 6'd0;
            state_d = S_EMIT;
          end else begin
            release_s = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Input_Reset) begin
    if (!Input_Reset) begin
      state_q           <= S_IDLE;
      tile_q            <= '0;
      idx_q             <= 6'd0;
      gap_q             <= '0;
      v1_q              <= 1'b0;
      done1_q           <= 1'b0;
      fd1_q             <= 1'b0;
      Output_Valid      <= 1'b0;
      Output_Pixel      <= 16'd0;
      Output_Tile_Done  <= 1'b0;
      Output_Frame_Done <= 1'b0;
    end else begin
      state_q           <= state_d;
      tile_q            <= tile_d;
      idx_q             <= idx_d;
      gap_q             <= gap_d;
      // Flags travel alongside the memory read so pixel and pulses stay aligned.
      v1_q              <= emit_s;
      done1_q           <= done_s;
      fd1_q             <= fdone_s;
      Output_Valid      <= v1_q;
      Output_Pixel      <= v1_q ? rd_data_q : 16'd0;
      Output_Tile_Done  <= done1_q;
      Output_Frame_Done <= fd1_q;
    end
  end

`ifdef TILER_OVERRUN_CNT_EN
  logic [15:0] watch_q;
  always_ff @(posedge Clock or negedge Input_Reset) begin
    if (!Input_Reset) begin
      watch_q <= 16'd0;
    end else if (accept && Input_Frame_Start) begin
      watch_q <= 16'd0;
    end else if (Input_Valid && !Input_Ready && (watch_q != 16'hFFFF)) begin
      watch_q <= watch_q + 16'd1;
    end
  end
  assign Watch = watch_q;
`else
  assign Watch = 16'd0;
`endif

endmodule

// File: tb/tb_raster_tiler.sv
// Bench for raster_tiler at IMG_WIDTH=16, IMG_HEIGHT=16, TILE_GAP=20.
// The reference model collects accepted pixels into a strip image and, when a
// strip completes, queues the tile-order pixels and per-tile frame-done flags.
module tb_raster_tiler;
  localparam int W      = 16;
  localparam int H      = 16;
  localparam int GAP    = 20;
  localparam int TILES  = W / 8;
  localparam int STRIPS = H / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n;
  logic [15:0] in_pix;
  logic        in_valid, in_fs;
  logic        in_ready;
  logic [15:0] out_pix;
  logic        out_valid, out_td, out_fd;
  logic [15:0] watch;

  raster_tiler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .TILE_GAP(GAP)) dut (
    .Clock(clk), .Input_Reset(rst_n), .Input_Pixel(in_pix),
    .Input_Valid(in_valid), .Input_Frame_Start(in_fs), .Input_Ready(in_ready),
    .Output_Pixel(out_pix), .Output_Valid(out_valid),
    .Output_Tile_Done(out_td), .Output_Frame_Done(out_fd), .Watch(watch)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] exp_q[$];
  bit          efd_q[$];
  int          rise_q[$];
  int          done_q[$];
  logic [15:0] strip_m [8][W];
  int m_cnt = 0, m_strips = 0;
  int td_n = 0, fd_n = 0, valid_seen = 0;
  int last_acc = 0;
  bit grab = 0;
  logic [15:0] first_pix = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_accept(input logic [15:0] pix, input bit fs);
    if (fs) begin
      m_cnt    = 0;
      m_strips = 0;
    end
    strip_m[m_cnt / W][m_cnt % W] = pix;
    m_cnt++;
    if (m_cnt == 8 * W) begin
      for (int t = 0; t < TILES; t++) begin
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            exp_q.push_back(strip_m[r][t * 8 + c]);
        efd_q.push_back((t == TILES - 1) && (m_strips % STRIPS == STRIPS - 1));
      end
      m_strips++;
      m_cnt = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] pix, input bit fs);
    bit ok = 0;
    in_pix   = pix;
    in_fs    = fs;
    in_valid = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (ok) begin
      model_accept(pix, fs);
      last_acc = cyc;
    end else begin
      check("send_timeout", {31'd0, ok}, 32'd1);
    end
    in_fs = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_fs    = 1'b0;
    in_pix   = 16'd0;
    exp_q.delete();
    efd_q.delete();
    m_cnt    = 0;
    m_strips = 0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pixel", {16'd0, out_pix}, 32'd0);
    check("rst_tile_done", {31'd0, out_td}, 32'd0);
    check("rst_frame_done", {31'd0, out_fd}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_watch", {16'd0, watch}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_at_release", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 check("ready_after_release", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || efd_q.size() != 0) && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", {31'd0, k < 6000}, 32'd1);
    repeat (GAP + 8) @(negedge clk);
  endtask

  // ---------------- output monitor ----------------
  initial begin
    int  run_len = 0;
    bit  prev_v  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0;
        prev_v  = 0;
      end else begin
        if (out_valid) begin
          check("pixel_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) check("pixel", {16'd0, out_pix}, {16'd0, exp_q.pop_front()});
          if (grab) begin
            first_pix = out_pix;
            grab = 0;
          end
          if (!prev_v) rise_q.push_back(cyc);
          run_len++;
          valid_seen++;
        end else if (prev_v) begin
          check("tile_run_len", run_len, 64);
          run_len = 0;
        end
        if (out_td) begin
          check("done_with_valid", {31'd0, out_valid}, 32'd0);
          done_q.push_back(cyc);
          td_n++;
          check("done_expected", {31'd0, efd_q.size() > 0}, 32'd1);
          if (efd_q.size() > 0) check("frame_done", {31'd0, out_fd}, {31'd0, efd_q.pop_front()});
        end else begin
          check("frame_done_alone", {31'd0, out_fd}, 32'd0);
        end
        if (out_fd) fd_n++;
        prev_v = out_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t_acc, stalls, rise_cyc, td0, fd0, base, k;
    bit rose;
    logic [15:0] fs_val;
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_fs = 1'b0;
    in_pix = 16'd0;
    #3 do_reset();

    // Streaming frame, pixel = row*16+col, and latency / gap timing.
    rise_q.delete();
    done_q.delete();
    td0 = td_n;
    fd0 = fd_n;
    t_acc = 0;
    for (int i = 0; i < 256; i++) begin
      send(16'(i), i == 0);
      if (i == 127) t_acc = last_acc;
    end

    // Backpressure: both banks full now; hold the next pixel.
    in_pix = 16'($urandom);
    in_fs = 1'b0;
    in_valid = 1'b1;
    stalls = 0;
    rose = 0;
    rise_cyc = 0;
    @(negedge clk);
    check("ready_low_both_full", {31'd0, in_ready}, 32'd0);
    for (k = 0; k < 2000; k++) begin
`ifdef TILER_OVERRUN_CNT_EN
      check("watch", {16'd0, watch}, stalls);
`else
      check("watch", {16'd0, watch}, 32'd0);
`endif
      if (in_ready) begin
        rose = 1;
        rise_cyc = cyc;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    check("ready_rose", {31'd0, rose}, 32'd1);
    @(posedge clk);
    #1;
    if (rose) model_accept(in_pix, 0);
    check("first_valid_latency", (rise_q.size() > 0) ? rise_q[0] - t_acc : -1, 3);
    check("tile_done_time", (done_q.size() > 0) ? done_q[0] - t_acc : -1, 67);
    check("tile1_valid_time", (rise_q.size() > 1) ? rise_q[1] - t_acc : -1, 68 + GAP);
    check("ready_after_release", (done_q.size() > 1) ? rise_cyc - done_q[1] : -1, GAP - 1);

    // Rest of a second frame: random pixels with random idle gaps.
    for (int i = 1; i < 256; i++) begin
      send(16'($urandom), 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    check("tile_done_count", td_n - td0, 4 * 2);
    check("frame_done_count", fd_n - fd0, 2);

    // Frame restart at pixel 50 of strip 0.
    td0 = td_n;
    fd0 = fd_n;
    grab = 1;
    for (int i = 0; i < 50; i++) send(16'($urandom), i == 0);
    fs_val = 16'($urandom);
    send(fs_val, 1);
    for (int i = 1; i < 256; i++) send(16'($urandom), 0);
    drain();
    check("restart_first_pixel", {16'd0, first_pix}, {16'd0, fs_val});
    check("restart_tile_count", td_n - td0, 4);
    check("restart_frame_count", fd_n - fd0, 1);

    // Reset in the middle of a tile.
    for (int i = 0; i < 128; i++) send(16'($urandom), i == 0);
    in_valid = 1'b0;
    base = valid_seen;
    k = 0;
    while (valid_seen - base < 28 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("mid_tile_reached", {31'd0, k < 1000}, 32'd1);
    td0 = td_n;
    #2 do_reset();
    repeat (120) @(negedge clk);
    check("no_done_after_reset", td_n - td0, 0);

    // Recovery frame with random gaps.
    td0 = td_n;
    fd0 = fd_n;
    for (int i = 0; i < 256; i++) begin
      send(16'($urandom), i == 0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    drain();
    check("recover_tile_count", td_n - td0, 4);
    check("recover_frame_count", fd_n - fd0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
